// File: rtl/from_nbit_packer.sv
// Packs IN_W-bit input words into 1..MAX_LANES-lane output words, with the lane count chosen per word by dataS.
// Optional parity output is built when FROM_NBIT_PARITY_EN is defined.
module from_nbit_packer #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned MAX_LANES = 4,
  parameter int unsigned SEL_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enb,
  input  logic [IN_W-1:0]           dataIn,
  input  logic                      validIn,
  output logic                      readyIn,
  input  logic [SEL_W-1:0]          dataS,
  output logic [IN_W*MAX_LANES-1:0] dataOut,
  output logic                      validOut,
  input  logic                      readyOut
`ifdef FROM_NBIT_PARITY_EN
  ,
  output logic                      parityOut
`endif
);

  localparam int unsigned OUT_W      = IN_W * MAX_LANES;
  localparam int unsigned LOG2_LANES = $clog2(MAX_LANES);
  localparam int unsigned CNT_W      = (LOG2_LANES < 1) ? 1 : LOG2_LANES;
  localparam int unsigned LANE_W     = $clog2(MAX_LANES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [LANE_W-1:0]   modeL;
  logic [LANE_W-1:0]   selL;
  logic [LANE_W-1:0]   curL;
  logic [OUT_W-1:0]    acc;
  logic [OUT_W-1:0]    nextWord;
  logic                lastBeat;
  logic                inBeat;
  logic                outBeat;

  // Lanes per word for a select value; selects past log2(MAX_LANES) clamp to MAX_LANES.
  function automatic logic [LANE_W-1:0] lanesFor(input logic [SEL_W-1:0] s);
    if (32'(s) >= LOG2_LANES) begin
      return LANE_W'(MAX_LANES);
    end
    return LANE_W'(1) << s;
  endfunction

  // The lane count is sampled from dataS only on the first beat of a word.
  assign selL     = lanesFor(dataS);
  assign curL     = (state == IDLE) ? selL : modeL;
  assign lastBeat = (LANE_W'(count) == (curL - LANE_W'(1)));

  // Only the beat that would complete a word stalls behind a held output.
  assign readyIn  = enb && !rst && !(validOut && !readyOut && lastBeat);
  assign inBeat   = validIn && readyIn;
  assign outBeat  = validOut && readyOut && enb;

  // First beat lands in the most significant used lane; later beats shift it up.
  assign nextWord = ((state == IDLE) ? {OUT_W{1'b0}} : (acc << IN_W)) | OUT_W'(dataIn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      modeL    <= '0;
      acc      <= '0;
      dataOut  <= '0;
      validOut <= 1'b0;
`ifdef FROM_NBIT_PARITY_EN
      parityOut <= 1'b0;
`endif
    end else begin
      if (inBeat) begin
        if (state == IDLE) begin
          modeL <= selL;
        end
        if (lastBeat) begin
          state <= IDLE;
          count <= '0;
          acc   <= '0;
        end else begin
          state <= FILL;
          count <= count + CNT_W'(1);
          acc   <= nextWord;
        end
      end

      // A completing beat overwrites the output even while it is being consumed.
      if (inBeat && lastBeat) begin
        dataOut  <= nextWord;
        validOut <= 1'b1;
`ifdef FROM_NBIT_PARITY_EN
        parityOut <= ^nextWord;
`endif
      end else if (outBeat) begin
        validOut <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_from_nbit_packer.sv
// Bench for from_nbit_packer: directed vector table, hand sequences and random traffic vs a queue-based model.
module tb_from_nbit_packer;

  localparam int unsigned IN_W      = 8;
  localparam int unsigned MAX_LANES = 4;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned OUT_W     = IN_W * MAX_LANES;

  logic             clk;
  logic             rst;
  logic             enb;
  logic [IN_W-1:0]  dataIn;
  logic             validIn;
  logic             readyIn;
  logic [SEL_W-1:0] dataS;
  logic [OUT_W-1:0] dataOut;
  logic             validOut;
  logic             readyOut;
`ifdef FROM_NBIT_PARITY_EN
  logic             parityOut;
`endif

  int checks = 0;
  int errors = 0;

  from_nbit_packer #(.IN_W(IN_W), .MAX_LANES(MAX_LANES), .SEL_W(SEL_W)) dut (
    .clk(clk),
    .rst(rst),
    .enb(enb),
    .dataIn(dataIn),
    .validIn(validIn),
    .readyIn(readyIn),
    .dataS(dataS),
    .dataOut(dataOut),
    .validOut(validOut),
    .readyOut(readyOut)
`ifdef FROM_NBIT_PARITY_EN
    ,
    .parityOut(parityOut)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Directed vectors: inputs for one cycle, readyIn before the edge, outputs after it.
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [1:0] s;
    logic       ro;
    logic       e;
    logic       rdy;
    logic       vo;
    logic [31:0] dout;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic v, input logic [7:0] d, input logic [1:0] s, input logic ro,
                      input logic e, input logic rdy, input logic vo, input logic [31:0] dout);
    vec_t x;
    x = '{v, d, s, ro, e, rdy, vo, dout};
    tbl.push_back(x);
  endtask

  // Behavioural model: pending bytes, latched lane count, single output slot.
  logic [7:0]  mBytes[$];
  int          mL;
  logic        mValid;
  logic [31:0] mData;

  function automatic int lanesOf(input int s);
    int l;
    l = 1 << s;
    return (l > int'(MAX_LANES)) ? int'(MAX_LANES) : l;
  endfunction

  task automatic mreset();
    mBytes.delete();
    mL = 0;
    mValid = 1'b0;
    mData = '0;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic [1:0] s, input logic ro,
                       input logic e);
    int   l;
    logic expRdy;
    logic inB;
    logic outB;
    logic [31:0] w;
    validIn = v; dataIn = d; dataS = s; readyOut = ro; enb = e;
    #1;
    l = (mBytes.size() == 0) ? lanesOf(int'(s)) : mL;
    expRdy = e && !(mValid && !ro && (mBytes.size() == l - 1));
    chk("readyIn", 32'(readyIn), 32'(expRdy));
    inB  = v && expRdy;
    outB = mValid && ro && e;
    @(posedge clk);
    #1;
    if (inB) begin
      if (mBytes.size() == 0) mL = l;
      mBytes.push_back(d);
      if (mBytes.size() == mL) begin
        w = '0;
        for (int i = 0; i < mL; i++) w |= 32'(mBytes[i]) << (8 * (mL - 1 - i));
        mData = w;
        mValid = 1'b1;
        mBytes.delete();
      end else if (outB) begin
        mValid = 1'b0;
      end
    end else if (outB) begin
      mValid = 1'b0;
    end
    chk("validOut", 32'(validOut), 32'(mValid));
    if (mValid) chk("dataOut", dataOut, mData);
`ifdef FROM_NBIT_PARITY_EN
    chk("parityOut", 32'(parityOut), 32'(^mData));
`endif
  endtask

  initial begin
    logic [1:0] rs;
    rst = 1'b1; enb = 1'b1; validIn = 1'b0; dataIn = '0; dataS = '0; readyOut = 1'b1;
    #3;
    chk("reset readyIn", 32'(readyIn), 32'h0);
    chk("reset validOut", 32'(validOut), 32'h0);
    chk("reset dataOut", dataOut, 32'h0);
`ifdef FROM_NBIT_PARITY_EN
    chk("reset parityOut", 32'(parityOut), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    //    v  d      s  ro e  rdy vo dout
    addv(1, 8'hd4, 0, 1, 1, 1, 1, 32'h000000d4);
    addv(0, 8'h00, 0, 1, 1, 1, 0, 32'h0);
    addv(1, 8'he4, 1, 1, 1, 1, 0, 32'h0);
    addv(1, 8'h57, 1, 1, 1, 1, 1, 32'h0000e457);
    addv(0, 8'h00, 1, 1, 1, 1, 0, 32'h0);
    addv(1, 8'hde, 2, 1, 1, 1, 0, 32'h0);
    addv(1, 8'had, 2, 1, 1, 1, 0, 32'h0);
    addv(1, 8'hbe, 2, 1, 1, 1, 0, 32'h0);
    addv(1, 8'hef, 2, 1, 1, 1, 1, 32'hdeadbeef);
    addv(0, 8'h00, 2, 1, 1, 1, 0, 32'h0);
    addv(1, 8'h11, 2, 0, 1, 1, 0, 32'h0);
    addv(1, 8'h22, 2, 0, 1, 1, 0, 32'h0);
    addv(1, 8'h33, 2, 0, 1, 1, 0, 32'h0);
    addv(1, 8'h44, 2, 0, 1, 1, 1, 32'h11223344);
    addv(1, 8'h55, 2, 0, 1, 1, 1, 32'h11223344);
    addv(1, 8'h66, 2, 0, 1, 1, 1, 32'h11223344);
    addv(1, 8'h77, 2, 0, 1, 1, 1, 32'h11223344);
    addv(1, 8'h88, 2, 0, 1, 0, 1, 32'h11223344);
    addv(1, 8'h88, 2, 1, 1, 1, 1, 32'h55667788);
    addv(0, 8'h00, 2, 1, 1, 1, 0, 32'h0);
    addv(1, 8'h5a, 0, 1, 0, 0, 0, 32'h0);
    addv(1, 8'h5a, 0, 0, 1, 1, 1, 32'h0000005a);
    addv(0, 8'h00, 0, 1, 0, 0, 1, 32'h0000005a);
    addv(1, 8'h07, 0, 0, 1, 0, 1, 32'h0000005a);
    addv(1, 8'h07, 0, 1, 1, 1, 1, 32'h00000007);
    addv(0, 8'h00, 0, 1, 1, 1, 0, 32'h0);
    addv(1, 8'h01, 3, 1, 1, 1, 0, 32'h0);
    addv(1, 8'h02, 3, 1, 1, 1, 0, 32'h0);
    addv(1, 8'h03, 3, 1, 1, 1, 0, 32'h0);
    addv(1, 8'h04, 3, 1, 1, 1, 1, 32'h01020304);
    addv(0, 8'h00, 3, 1, 1, 1, 0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      validIn = tbl[i].v; dataIn = tbl[i].d; dataS = tbl[i].s;
      readyOut = tbl[i].ro; enb = tbl[i].e;
      #1;
      chk($sformatf("vec%0d readyIn", i), 32'(readyIn), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d validOut", i), 32'(validOut), 32'(tbl[i].vo));
      if (tbl[i].vo) chk($sformatf("vec%0d dataOut", i), dataOut, tbl[i].dout);
`ifdef FROM_NBIT_PARITY_EN
      if (tbl[i].vo) chk($sformatf("vec%0d parityOut", i), 32'(parityOut), 32'(^tbl[i].dout));
`endif
    end

    rst = 1'b1; validIn = 1'b0;
    #1;
    rst = 1'b0;
    mreset();

    // Mode change mid-word only affects the following word.
    cycle(1, 8'h76, 1, 1, 1);
    cycle(1, 8'hd6, 0, 1, 1);
    chk("modeswitch word", dataOut, 32'h000076d6);
    cycle(1, 8'h3c, 0, 1, 1);
    chk("modeswitch next", dataOut, 32'h0000003c);
    cycle(0, 8'h00, 0, 1, 1);

    // Asynchronous reset in the middle of a cycle with a partial word pending.
    cycle(1, 8'h99, 0, 0, 1);
    cycle(1, 8'haa, 2, 0, 1);
    cycle(1, 8'hbb, 2, 0, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst validOut", 32'(validOut), 32'h0);
    chk("midrst dataOut", dataOut, 32'h0);
    chk("midrst readyIn", 32'(readyIn), 32'h0);
    #1;
    rst = 1'b0;
    mreset();
    cycle(1, 8'h01, 2, 1, 1);
    cycle(1, 8'h02, 2, 1, 1);
    cycle(1, 8'h03, 2, 1, 1);
    cycle(1, 8'h04, 2, 1, 1);
    chk("fresh word", dataOut, 32'h01020304);
    chk("fresh valid", 32'(validOut), 32'h1);

    rs = 2'd0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) rs = 2'($urandom_range(0, 3));
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), rs,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
